ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the shared single-port 256x16 synchronous block RAM. Port 0 is the switch-entry writer; port 1 is the display/readback scanner. Either port may read or write. The arbiter issues at most one registered RAM command per cycle and returns read data with a valid strobe tagged to the requesting port. It sits between the requester logic and the RAM core instance in the top level.

## Interface
- AW, 8, RAM address width (256 words)
- DW, 16, RAM data width
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  access request; held until the matching gnt
- we0, we1  in  1 each  1 = write, 0 = read; held with req
- addr0, addr1  in  AW each  access address; held with req
- wdata0, wdata1  in  DW each  write data; held with req
- gnt0, gnt1  out  1 each  one-cycle pulse; the command has been issued to the RAM
- rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata holds read data for that port
- rdata  out  DW  read data, shared by both ports, qualified by rvalid0/rvalid1
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  AW  RAM address (registered)
- ram_din  out  DW  RAM write data (registered)
- ram_dout  in  DW  RAM read data, valid 1 cycle after the address edge

## Operation
- Each cycle the arbiter evaluates eligible requests. A port is eligible when req=1 and its gnt is not high in the current cycle. This mask prevents a double grant while the requester is still seeing gnt.
- One eligible port: that port wins.
- Both ports eligible: the port named by priority pointer `prio` wins. After any grant, `prio` moves to the other port.
- Winner's command is registered onto ram_we/ram_addr/ram_din. gnt of the winner pulses in that same registered cycle.
- No winner: ram_we is forced to 0. ram_addr and ram_din hold their previous values.
- Read grant: a 2-entry tag pipeline records {read, port}. One cycle after gnt, rdata = ram_dout and the tagged rvalid pulses.
- Write grant: ram_we=1 for exactly one cycle. No rvalid is generated.
- Write then read of the same address on consecutive grants: the read returns the newly written data (RAM write-first ordering is not relied on, because the commands are sequential).
- Full throughput is one command per cycle only when the two ports alternate. A single port gets at most one grant every 2 cycles.
- Requester dropping req before gnt: the request is withdrawn and no command is issued. Changing we/addr/wdata while req=1 is a protocol violation, and its behaviour is undefined.

## Timing
- Reset (reset_n=0, asynchronous): gnt0/1=0, rvalid0/1=0, ram_we=0, ram_addr=0, ram_din=0, rdata=0, prio=port 0, tag pipeline cleared.
- Release: the first grant can occur on the first rising edge after reset_n rises.
- Request latency: req sampled at edge N, gnt and RAM command visible after edge N, rvalid/rdata visible after edge N+1.
- Reset asserted mid-operation: any in-flight read is discarded, its rvalid is never produced, and no RAM write is issued after reset asserts.
- rdata holds its last value when no rvalid is high.

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration as described above; `prio` toggles after each grant.
- RAM_ARB_RR_EN undefined: fixed priority, with port 0 always winning a conflict. `prio` is not implemented. All other behaviour is identical.

## Test plan
- Port 0 writes 0xBEEF to addr 0x10; two cycles later, port 1 reads 0x10. Required: gnt0 one cycle after req0, ram_we=1 for one cycle, rvalid1 with rdata=0xBEEF one cycle after gnt1.
- Both ports request a read in the same cycle after reset (addr 0x01/0x02, preloaded 0x1111/0x2222).
  - With RR: gnt0, then gnt1 the next cycle.
  - rvalid0 carries 0x1111 and rvalid1 carries 0x2222 on consecutive cycles.
- Both ports hold req continuously for 8 cycles with RR.
  - Required: grants alternate 0,1,0,1…, with a command every cycle and no port granted twice in a row.
  - Without RR, port 0 is granted every other cycle and port 1 only in the gaps.
- Single port 1 issues back-to-back read requests. Required: gnt1 at most once per 2 cycles, and ram_we=0 in the idle gap.
- Read granted, then reset_n pulsed low before rvalid. Required: no rvalid, all outputs 0, and the next conflict is won by port 0.
- Port 0 raises req0 for one cycle while port 1 is being granted, then drops it. Required: no gnt0 and no RAM command for port 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a shared single-port 256x16 synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          elig0_s;
  logic          elig1_s;
  logic          win0_s;
  logic          win1_s;
  logic          win_any_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_din_s;
  logic          tag_vld_r;
  logic          tag_port_r;

`ifdef RAM_ARB_RR_EN
  logic          prio_r;
`endif

  // Eligibility masking and winner selection
  always_comb begin
    elig0_s = req0 & ~gnt0;
    elig1_s = req1 & ~gnt1;
    win0_s  = 1'b0;
    win1_s  = 1'b0;
`ifdef RAM_ARB_RR_EN
    if (elig0_s && elig1_s) begin
      win0_s = ~prio_r;
      win1_s = prio_r;
    end else begin
      win0_s = elig0_s;
      win1_s = elig1_s;
    end
`else
    if (elig0_s) begin
      win0_s = 1'b1;
      win1_s = 1'b0;
    end else begin
      win0_s = 1'b0;
      win1_s = elig1_s;
    end
`endif
    win_any_s = win0_s | win1_s;
  end

  // Command mux for the winning port (port 0 fields when nobody wins; unused then)
  always_comb begin
    sel_we_s   = we0;
    sel_addr_s = addr0;
    sel_din_s  = wdata0;
    if (win1_s) begin
      sel_we_s   = we1;
      sel_addr_s = addr1;
      sel_din_s  = wdata1;
    end else begin
      sel_we_s   = we0;
      sel_addr_s = addr0;
      sel_din_s  = wdata0;
    end
  end

  // Grant, RAM command and read-tag registers; an idle cycle keeps address/data but drops we
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= {AW{1'b0}};
      ram_din    <= {DW{1'b0}};
      tag_vld_r  <= 1'b0;
      tag_port_r <= 1'b0;
    end else begin
      gnt0       <= win0_s;
      gnt1       <= win1_s;
      ram_we     <= win_any_s & sel_we_s;
      tag_vld_r  <= win_any_s & ~sel_we_s;
      tag_port_r <= win1_s;
      if (win_any_s) begin
        ram_addr <= sel_addr_s;
        ram_din  <= sel_din_s;
      end else begin
        ram_addr <= ram_addr;
        ram_din  <= ram_din;
      end
    end
  end

  // Read return: capture RAM data one cycle after the read command and strobe the tagged port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= {DW{1'b0}};
    end else begin
      rvalid0 <= tag_vld_r & ~tag_port_r;
      rvalid1 <= tag_vld_r & tag_port_r;
      if (tag_vld_r) begin
        rdata <= ram_dout;
      end else begin
        rdata <= rdata;
      end
    end
  end

`ifdef RAM_ARB_RR_EN
  // Priority pointer moves to the port that did not win the last grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_r <= 1'b0;
    end else if (win_any_s) begin
      prio_r <= win0_s;
    end else begin
      prio_r <= prio_r;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized requesters
// compared every cycle against a transaction-level reference model.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 1) return 16'h1111;
    else if (i == 2) return 16'h2222;
    else return {i[7:0], ~i[7:0]};
  endfunction

  // RAM core stand-in: registered address from the arbiter, data readable in the following cycle
  logic          init_done;
  logic [DW-1:0] ram [256];
  assign ram_dout = ram[ram_addr];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of what the arbiter should be showing
  logic [DW-1:0] ref_mem [256];
  logic          m_gnt0, m_gnt1, m_rv0, m_rv1, m_we, m_prio;
  logic [DW-1:0] m_rdata, m_din;
  logic [AW-1:0] m_addr;
  logic          m_rd_pend, m_rd_port, m_wr_pend;
  logic [DW-1:0] m_rd_data, m_wr_data;
  logic [AW-1:0] m_wr_addr;

  task automatic model_reset();
    m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_we = 1'b0;
    m_prio = 1'b0; m_rdata = '0; m_din = '0; m_addr = '0;
    m_rd_pend = 1'b0; m_rd_port = 1'b0; m_wr_pend = 1'b0;
    m_rd_data = '0; m_wr_data = '0; m_wr_addr = '0;
  endtask

  task automatic compare_all();
    check_eq("gnt0", 32'(gnt0), 32'(m_gnt0));
    check_eq("gnt1", 32'(gnt1), 32'(m_gnt1));
    check_eq("rvalid0", 32'(rvalid0), 32'(m_rv0));
    check_eq("rvalid1", 32'(rvalid1), 32'(m_rv1));
    check_eq("ram_we", 32'(ram_we), 32'(m_we));
    check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
    check_eq("ram_din", 32'(ram_din), 32'(m_din));
    check_eq("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  // One clock: predict from current inputs, advance, compare
  task automatic step();
    int w;
    logic e0, e1, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    if (m_wr_pend) ref_mem[m_wr_addr] = m_wr_data;
    m_wr_pend = 1'b0;
    e0 = req0 && !m_gnt0;
    e1 = req1 && !m_gnt1;
    if (e0 && e1) w = (RR && m_prio) ? 1 : 0;
    else if (e0) w = 0;
    else if (e1) w = 1;
    else w = -1;
    m_rv0 = m_rd_pend && !m_rd_port;
    m_rv1 = m_rd_pend && m_rd_port;
    if (m_rd_pend) m_rdata = m_rd_data;
    m_rd_pend = 1'b0;
    m_gnt0 = (w == 0);
    m_gnt1 = (w == 1);
    m_we = 1'b0;
    if (w >= 0) begin
      cw = (w == 1) ? we1 : we0;
      ca = (w == 1) ? addr1 : addr0;
      cd = (w == 1) ? wdata1 : wdata0;
      m_addr = ca;
      m_din = cd;
      m_we = cw;
      if (cw) begin
        m_wr_pend = 1'b1; m_wr_addr = ca; m_wr_data = cd;
      end else begin
        m_rd_pend = 1'b1; m_rd_port = (w == 1); m_rd_data = ref_mem[ca];
      end
      m_prio = (w == 0);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // Assert reset away from the clock edge, check the reset state, release after an edge
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  // Random requester behaviour: hold until gnt, occasionally withdraw, addresses clustered for hits
  task automatic drive_random();
    if (m_gnt0) req0 = 1'b0;
    if (m_gnt1) req1 = 1'b0;
    if (!req0) begin
      if ($urandom_range(1) == 1) begin
        req0 = 1'b1; we0 = $urandom_range(1) == 1;
        addr0 = AW'($urandom_range(7)); wdata0 = DW'($urandom);
      end
    end else if ($urandom_range(15) == 0) begin
      req0 = 1'b0;
    end
    if (!req1) begin
      if ($urandom_range(1) == 1) begin
        req1 = 1'b1; we1 = $urandom_range(1) == 1;
        addr1 = AW'($urandom_range(7)); wdata1 = DW'($urandom);
      end
    end else if ($urandom_range(15) == 0) begin
      req1 = 1'b0;
    end
  endtask

  initial begin
    init_done = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    init_done = 1'b1;
    do_reset();

    // Simultaneous reads right after reset
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    step();
    check_eq("both_first_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    step();
    check_eq("both_second_gnt1", 32'(gnt1), 32'd1);
    check_eq("both_rdata0", 32'(rdata), 32'h1111);
    req1 = 1'b0;
    step();
    check_eq("both_rvalid1", 32'(rvalid1), 32'd1);
    check_eq("both_rdata1", 32'(rdata), 32'h2222);

    // Port 0 writes, port 1 reads back two cycles later
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hBEEF;
    step();
    check_eq("wr_gnt0", 32'(gnt0), 32'd1);
    check_eq("wr_ram_we", 32'(ram_we), 32'd1);
    req0 = 1'b0;
    step();
    check_eq("wr_we_single", 32'(ram_we), 32'd0);
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    step();
    req1 = 1'b0;
    step();
    check_eq("rd_beef", 32'(rdata), 32'hBEEF);

    // Both hold requests continuously: alternating grants every cycle
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h21;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("hold_one_gnt", 32'(gnt0 ^ gnt1), 32'd1);
    end
    idle_inputs();
    step();
    step();

    // Single port back-to-back reads
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    for (int i = 0; i < 6; i++) step();
    req1 = 1'b0;
    step();
    step();

    // Read in flight when reset is pulsed
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    step();
    req0 = 1'b0;
    do_reset();
    step();
    check_eq("rst_no_rvalid", 32'(rvalid0), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h04;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h06;
    step();
    check_eq("post_rst_win0", 32'(gnt0), 32'd1);
    idle_inputs();
    step();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end
    idle_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
